// File: rtl/bsalu_pkg.sv
// bsalu_pkg: op codes and controller states shared by the bit-serial ALU
// controller and its 1-bit slice.
package bsalu_pkg;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_OR} alu_op_e;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: combinational 1-bit ALU slice. The carry flop lives in the
// controller; logic ops report cout=0 so the carry chain stays cleared.
module alu_bit_slice
  import bsalu_pkg::*;
(
  input  logic    op1_i,
  input  logic    op2_i,
  input  logic    cin_i,
  input  alu_op_e op_i,
  output logic    res_o,
  output logic    cout_o
);

  always_comb begin
    res_o  = 1'b0;
    cout_o = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB: begin
        res_o  = op1_i ^ op2_i ^ cin_i;
        cout_o = (op1_i & op2_i) | (cin_i & (op1_i ^ op2_i));
      end
      OP_AND:  res_o = op1_i & op2_i;
      OP_OR:   res_o = op1_i | op2_i;
      default: res_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// bit_serial_alu_ctrl: streams two WIDTH-bit operands LSB-first through one
// alu_bit_slice and reassembles the result plus C/Z/O/S flags.
// Optional macro BSALU_CARRY_IN_EN adds a cin port for multi-word chaining.
module bit_serial_alu_ctrl
  import bsalu_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef BSALU_CARRY_IN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_flag,
  output logic             z_flag,
  output logic             o_flag,
  output logic             s_flag
);

  state_e             state_q;
  alu_op_e            op_q;
  logic [WIDTH-1:0]   a_sr_q;
  logic [WIDTH-1:0]   b_sr_q;
  logic [WIDTH-1:0]   res_sr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               cmsb_q;
  logic               zacc_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic               c_q;
  logic               z_q;
  logic               o_q;
  logic               s_q;

  logic               carry_init;
  logic               bit_res;
  logic               bit_cout;
  logic [WIDTH-1:0]   res_d;
  logic               last_bit;
  logic               msb_in_bit;

  always_comb begin
`ifdef BSALU_CARRY_IN_EN
    carry_init = (op == OP_ADD || op == OP_SUB) ? cin : 1'b0;
`else
    carry_init = (op == OP_SUB);
`endif
  end

  alu_bit_slice u_slice (
    .op1_i  (a_sr_q[0]),
    .op2_i  (b_sr_q[0] ^ (op_q == OP_SUB)),
    .cin_i  (carry_q),
    .op_i   (op_q),
    .res_o  (bit_res),
    .cout_o (bit_cout)
  );

  // New bit enters at the MSB; after WIDTH shifts the word is in place.
  assign res_d      = WIDTH'({bit_res, res_sr_q} >> 1);
  assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));
  assign msb_in_bit = (cnt_q == CNT_W'(WIDTH - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      zacc_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      o_q      <= 1'b0;
      s_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            op_q    <= alu_op_e'(op);
            cnt_q   <= '0;
            carry_q <= carry_init;
            cmsb_q  <= 1'b0;
            zacc_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          res_sr_q <= res_d;
          carry_q  <= bit_cout;
          zacc_q   <= zacc_q & ~bit_res;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (msb_in_bit) cmsb_q <= bit_cout;
          if (last_bit) begin
            result_q <= res_d;
            c_q      <= bit_cout;
            o_q      <= cmsb_q ^ bit_cout;
            z_q      <= zacc_q & ~bit_res;
            s_q      <= bit_res;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign c_flag = c_q;
  assign z_flag = z_q;
  assign o_flag = o_q;
  assign s_flag = s_q;

endmodule
